// File: rtl/number_field_if.sv
// Load/busy handshake carrying the binary value into the number renderer
// and the converter status back out.
interface number_field_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               busy;
    logic               overflow;

    modport master (output value, output load, input busy, input overflow);
    modport slave  (input value, input load, output busy, output overflow);
endinterface

// File: rtl/number_field.sv
// Multi-digit decimal renderer: sequential double-dabble conversion with an
// atomic digit commit, plus a 3-stage pixel pipeline around the glyph ROM.
module number_field #(
    parameter int           DIGITS         = 4,
    parameter int           VALUE_W        = 14,
    parameter int           WIDTH_NUMBERS  = 21,
    parameter int           HEIGHT_NUMBERS = 23,
    parameter logic [5:0]   INK            = 6'b000011,
    parameter logic [5:0]   BACKGROUND     = 6'b111111,
    parameter bit           BLANK_LEADING  = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [9:0]           x_px,
    input  logic [9:0]           y_px,
    input  logic [9:0]           x_pos,
    input  logic [9:0]           y_pos,
    number_field_if.slave        ld,
    output logic [7:0]           x_img,
    output logic [7:0]           y_img,
    input  logic                 pixel,
    output logic [5:0]           color_px
);
    // Seven accumulator nibbles hold any 20-bit input, so bits above the
    // guard digit are never shifted out before the overflow test.
    localparam int ACC_N   = 7;
    localparam int ACC_W   = 4 * ACC_N;
    localparam int FIELD_W = DIGITS * WIDTH_NUMBERS;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [VALUE_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_adj;
    logic [4:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        acc_adj  = acc_q;
        for (int i = 0; i < ACC_N; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (ld.load) begin
                    bin_d   = ld.value;
                    acc_d   = '0;
                    cnt_d   = 5'(VALUE_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = {acc_adj[ACC_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                ovf_d    = |acc_q[ACC_W-1:4*DIGITS];
                digits_d = ovf_d ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ld.busy     = (state_q != IDLE);
    assign ld.overflow = ovf_q;

    // Digit 0 is the most significant nibble of the committed register.
    logic [3:0] digit_nib [DIGITS];
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign digit_nib[gi] = digits_q[4*(DIGITS-1-gi) +: 4];
    end

    logic [11:0]       rel_x, rel_y, x_base;
    logic              inside0, blank0;
    logic [2:0]        sel;
    logic [3:0]        sel_nib;
    logic [DIGITS-1:0] lead_zero;
    logic              run_zero;
    logic [7:0]        x_img_d, y_img_d;

    always_comb begin
        rel_x   = {2'b00, x_px} - {2'b00, x_pos};
        rel_y   = {2'b00, y_px} - {2'b00, y_pos};
        inside0 = (x_px >= x_pos) && (rel_x < 12'(FIELD_W)) &&
                  (y_px >= y_pos) && (rel_y < 12'(HEIGHT_NUMBERS));
        sel    = 3'd0;
        x_base = 12'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (rel_x >= 12'(i * WIDTH_NUMBERS)) begin
                sel    = 3'(i);
                x_base = 12'(i * WIDTH_NUMBERS);
            end
        end
        run_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            run_zero     = run_zero && (digit_nib[i] == 4'd0);
            lead_zero[i] = run_zero;
        end
        sel_nib = digit_nib[sel];
        blank0  = BLANK_LEADING && lead_zero[sel] && (sel != 3'(DIGITS - 1));
        x_img_d = 8'd0;
        y_img_d = 8'd0;
        if (inside0) begin
            x_img_d = 8'(rel_x - x_base);
            y_img_d = 8'(rel_y + 12'(sel_nib) * 12'(HEIGHT_NUMBERS));
        end
    end

    logic       inside1_q, blank1_q, inside2_q, blank2_q;
    logic [7:0] x_img_q, y_img_q;
    logic [5:0] color_q, color_d;

    always_comb begin
        color_d = BACKGROUND;
        if (inside2_q && !blank2_q && pixel) begin
            color_d = INK;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            ovf_q     <= 1'b0;
            x_img_q   <= '0;
            y_img_q   <= '0;
            inside1_q <= 1'b0;
            blank1_q  <= 1'b0;
            inside2_q <= 1'b0;
            blank2_q  <= 1'b0;
            color_q   <= BACKGROUND;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
            x_img_q   <= x_img_d;
            y_img_q   <= y_img_d;
            inside1_q <= inside0;
            blank1_q  <= blank0;
            inside2_q <= inside1_q;
            blank2_q  <= blank1_q;
            color_q   <= color_d;
        end
    end

    assign x_img    = x_img_q;
    assign y_img    = y_img_q;
    assign color_px = color_q;
endmodule

// File: tb/tb_number_field.sv
// Directed bench for number_field: reset, conversion, overflow, addressing,
// pixel latency and leading-zero blanking (with and without blanking).
module tb_number_field;
    localparam logic [5:0] INK = 6'b000011;
    localparam logic [5:0] BG  = 6'b111111;

    logic       clk = 1'b0;
    logic       clr;
    logic [9:0] x_px, y_px, x_pos, y_pos;
    logic       pixel;
    logic       rom_val;
    logic [7:0] x_img_a, y_img_a, x_img_b, y_img_b;
    logic [5:0] color_a, color_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Registered ROM model: data appears one cycle after the address.
    always @(posedge clk) pixel <= rom_val;

    number_field_if #(.VALUE_W(14)) ld_a ();
    number_field_if #(.VALUE_W(14)) ld_b ();

    number_field #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .clr(clr), .x_px(x_px), .y_px(y_px), .x_pos(x_pos), .y_pos(y_pos),
        .ld(ld_a), .x_img(x_img_a), .y_img(y_img_a), .pixel(pixel), .color_px(color_a)
    );

    number_field #(.BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .clr(clr), .x_px(x_px), .y_px(y_px), .x_pos(x_pos), .y_pos(y_pos),
        .ld(ld_b), .x_img(x_img_b), .y_img(y_img_b), .pixel(pixel), .color_px(color_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_load(input logic l, input logic [13:0] v);
        ld_a.load = l; ld_a.value = v;
        ld_b.load = l; ld_b.value = v;
    endtask

    task automatic do_load(input logic [13:0] v);
        int n;
        set_load(1'b1, v);
        step();
        set_load(1'b0, 14'd0);
        n = 0;
        while (ld_a.busy && n < 50) begin
            step();
            n++;
        end
        chk("load_busy_timeout", ld_a.busy, 0);
        $display("load value=%0d overflow=%0d", v, ld_a.overflow);
    endtask

    // Top row of digit d, column 1: y_img reads digit*23, x_img reads 1.
    task automatic chk_digit(input string tag, input int d, input int exp);
        x_px = 10'(100 + d * 21 + 1);
        y_px = 10'd50;
        step();
        chk({tag, "_x"}, x_img_a, 1);
        chk({tag, "_y"}, y_img_a, exp * 23);
        $display("%s digit%0d y_img=%0d", tag, d, y_img_a);
    endtask

    task automatic render(input int xp, input int yp, output logic [5:0] ca, output logic [5:0] cb);
        x_px = 10'(xp);
        y_px = 10'(yp);
        step(); step(); step();
        ca = color_a;
        cb = color_b;
        $display("render x=%0d y=%0d color=%b color_nb=%b", xp, yp, ca, cb);
    endtask

    initial begin
        logic [5:0] ca, cb;
        int         n;
        clr = 1'b1; x_pos = 10'd100; y_pos = 10'd50; x_px = 10'd0; y_px = 10'd0;
        rom_val = 1'b1;
        set_load(1'b1, 14'd1234);

        // Reset held for two cycles while a load is requested.
        step(); step();
        chk("rst_busy", ld_a.busy, 0);
        chk("rst_overflow", ld_a.overflow, 0);
        chk("rst_color", color_a, BG);
        chk("rst_ximg", x_img_a, 0);
        clr = 1'b0;
        set_load(1'b0, 14'd0);
        for (int d = 0; d < 4; d++) chk_digit("rst_digit", d, 0);

        // Reset mid-conversion aborts and leaves zeros.
        set_load(1'b1, 14'd1234);
        step();
        set_load(1'b0, 14'd0);
        step(); step(); step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        chk("abort_busy", ld_a.busy, 0);
        for (int i = 0; i < 20; i++) step();
        chk_digit("abort_digit", 0, 0);
        chk_digit("abort_digit", 3, 0);

        // Conversion of 1234 with an ignored load of 42 while busy.
        set_load(1'b1, 14'd1234);
        step();
        set_load(1'b0, 14'd0);
        n = 0;
        while (ld_a.busy && n < 40) begin
            if (n == 3) set_load(1'b1, 14'd42);
            else set_load(1'b0, 14'd0);
            n++;
            step();
        end
        set_load(1'b0, 14'd0);
        $display("busy cycles=%0d", n);
        chk("busy_cycles", n, 15);
        chk("conv_overflow", ld_a.overflow, 0);
        for (int d = 0; d < 4; d++) chk_digit("conv_digit", d, d + 1);
        step(); step();
        chk("no_queue_busy", ld_a.busy, 0);

        // Overflow saturation then the largest legal value.
        do_load(14'd12000);
        chk("ovf_flag", ld_a.overflow, 1);
        for (int d = 0; d < 4; d++) chk_digit("ovf_digit", d, 9);
        do_load(14'd9999);
        chk("max_flag", ld_a.overflow, 0);
        for (int d = 0; d < 4; d++) chk_digit("max_digit", d, 9);

        // Addressing with 1234 at (100,50).
        do_load(14'd1234);
        x_px = 10'd163; y_px = 10'd55; step();
        chk("addr163_x", x_img_a, 0);
        chk("addr163_y", y_img_a, 97);
        x_px = 10'd183; step();
        chk("addr183_x", x_img_a, 20);
        x_px = 10'd184; step();
        chk("addr184_x", x_img_a, 0);
        chk("addr184_y", y_img_a, 0);
        x_px = 10'd120; step();
        chk("addr120_x", x_img_a, 20);
        chk("addr120_y", y_img_a, 28);
        x_px = 10'd121; step();
        chk("addr121_x", x_img_a, 0);
        chk("addr121_y", y_img_a, 51);
        x_px = 10'd99; step();
        chk("addr99_y", y_img_a, 0);
        x_px = 10'd110; y_px = 10'd73; step();
        chk("addr_bottom_y", y_img_a, 0);

        // Colour latency: one inside pixel among outside pixels.
        x_px = 10'd0; y_px = 10'd50;
        step(); step(); step();
        x_px = 10'd110; step();
        x_px = 10'd0;
        chk("lat1_color", color_a, BG);
        step();
        chk("lat2_color", color_a, BG);
        step();
        chk("lat3_color", color_a, INK);
        step();
        chk("lat4_color", color_a, BG);
        rom_val = 1'b0;
        render(110, 50, ca, cb);
        chk("clear_pixel", ca, BG);
        rom_val = 1'b1;
        render(184, 50, ca, cb);
        chk("right_edge_color", ca, BG);

        // Leading-zero blanking.
        do_load(14'd7);
        for (int d = 0; d < 4; d++) begin
            render(100 + d * 21 + 5, 55, ca, cb);
            chk("blank7", ca, (d < 3) ? BG : INK);
            chk("noblank7", cb, INK);
        end
        do_load(14'd0);
        for (int d = 0; d < 4; d++) begin
            render(100 + d * 21 + 5, 55, ca, cb);
            chk("blank0", ca, (d < 3) ? BG : INK);
            chk("noblank0", cb, INK);
        end
        do_load(14'd205);
        render(100 + 5, 55, ca, cb);
        chk("blank205_d0", ca, BG);
        render(100 + 2 * 21 + 5, 55, ca, cb);
        chk("blank205_d2", ca, INK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/number_field.md
# number_field

Parametrised multi-digit number renderer for the VGA pixel pipeline. It accepts a binary value through a load/busy handshake, converts it to BCD with a sequential double-dabble engine, and holds the digits atomically. For every pixel it computes glyph coordinates into the shared digit image ROM (`image`, one-cycle registered read) and produces a registered 6-bit pixel colour. It supports leading-zero blanking and overflow saturation.

## Interface
- `DIGITS`, 4: number of decimal digits shown, 1..6.
- `VALUE_W`, 14: width of the binary input value, 1..20.
- `WIDTH_NUMBERS`, 21: glyph width in pixels.
- `HEIGHT_NUMBERS`, 23: glyph height in pixels. Constraint: 10*HEIGHT_NUMBERS <= 256.
- `INK`, 6'b000011: colour for glyph pixels that are set.
- `BACKGROUND`, 6'b111111: colour outside the field, for clear glyph pixels, and for blanked digits.
- `BLANK_LEADING`, 1: when 1, leading zero digits render as BACKGROUND.

Ports (clock and reset first):
- `clk`  in  1: system clock. This is the only clock.
- `clr`  in  1: reset, synchronous, active-high.
- `x_px`  in  10: current pixel X.
- `y_px`  in  10: current pixel Y.
- `x_pos`  in  10: field top-left X. Must be static while the field is scanned.
- `y_pos`  in  10: field top-left Y. Must be static while the field is scanned.
- `value`  in  VALUE_W: binary value to display. Sampled on an accepted load.
- `load`  in  1: load request.
- `busy`  out  1: conversion in progress.
- `overflow`  out  1: the last committed value exceeded 10^DIGITS-1.
- `x_img`  out  8: glyph ROM column, registered.
- `y_img`  out  8: glyph ROM row, registered.
- `pixel`  in  1: ROM data. Valid one cycle after `x_img`/`y_img`.
- `color_px`  out  6: pixel colour, registered.

## Operation
- The converter FSM has three states: IDLE, SHIFT and COMMIT.
  - IDLE: `load`=1 with `busy`=0 captures `value` into the shift register and clears the BCD accumulator (4*DIGITS+4 bits, one guard digit). The FSM then goes to SHIFT.
  - SHIFT: runs exactly VALUE_W iterations. Each iteration adds 3 to every BCD nibble >= 5, then shifts left one bit from the binary register. After the last iteration the FSM goes to COMMIT.
  - COMMIT: loads the displayed-digit register in one cycle, then returns to IDLE.
- Overflow at COMMIT: if the guard nibble, or any bit above it, is nonzero, every displayed digit is 9 and `overflow`=1. Otherwise `overflow`=0.
- `load` while `busy`=1 is ignored. No queueing.
- The displayed digits change only at COMMIT. A partially converted value is never rendered.
- Pixel stage 0 (combinational on `x_px`/`y_px`):
  - The pixel is inside the field when `x_pos` <= `x_px` < `x_pos`+DIGITS*WIDTH_NUMBERS and `y_pos` <= `y_px` < `y_pos`+HEIGHT_NUMBERS.
  - Digit index d = 0 (most significant) .. DIGITS-1. Select it with comparators against multiples of WIDTH_NUMBERS; no divider.
  - `x_img` = `x_px`-`x_pos`-d*WIDTH_NUMBERS.
  - `y_img` = (`y_px`-`y_pos`) + digit_value*HEIGHT_NUMBERS.
  - Both are truncated to 8 bits and registered. Outside the field, `x_img`=`y_img`=0.
- Blanking: digit d is blanked when BLANK_LEADING=1, every digit with index <= d is 0, and d != DIGITS-1. A value of 0 shows a single "0". The blank flag is computed in stage 0 and pipelined.
- Colour stage: outside the field or blanked gives BACKGROUND. Otherwise `pixel`=1 gives INK and `pixel`=0 gives BACKGROUND.

## Timing
- Reset (`clr`=1 at an edge):
  - FSM goes to IDLE, `busy`=0, `overflow`=0.
  - All displayed digits are 0.
  - `x_img`=`y_img`=0, pipeline flags are 0, `color_px`=BACKGROUND.
  - Reset mid-conversion aborts it. The digits are 0, not the old value.
- Handshake: with `load` accepted at edge N, `busy`=1 from N+1 through N+VALUE_W+1 (SHIFT plus COMMIT). New digits are visible from edge N+VALUE_W+2, where `busy`=0. The next load is accepted at that edge at the earliest.
- Pixel latency is 3 cycles:
  - `x_px`/`y_px` at cycle t.
  - `x_img`/`y_img` valid at t+1.
  - `pixel` valid at t+2.
  - `color_px` valid at t+3.
  - The inside and blank flags are delayed 2 stages to match.
- A digit commit during a scan takes effect for pixels whose stage 0 occurs after the commit edge. Tearing within a frame is acceptable.
- Field right edge: the column at `x_pos`+DIGITS*WIDTH_NUMBERS is outside. Boundary columns between digits belong to the right-hand digit.

## Test plan
- Reset: assert `clr` for 2 cycles during a load. Required: `busy`=0, `overflow`=0, `color_px`=6'b111111 at t+3 for any pixel, and all digits 0.
- Conversion: load 1234 (DIGITS=4). Required: `busy` is high for exactly 15 cycles, then the digits read 1,2,3,4 and `overflow`=0. A second `load` of 42 during `busy` has no effect.
- Overflow: load 12000 (VALUE_W=14). Required: digits 9,9,9,9 and `overflow`=1. Then load 9999. Required: 9,9,9,9 and `overflow`=0.
- Addressing: after loading 1234 with `x_pos`=100, `y_pos`=50, drive `x_px`=163, `y_px`=55. Required: at t+1, `x_img`=0 and `y_img`=5+4*23=97. At `x_px`=184: outside, `x_img`=0, `y_img`=0.
- Colour pipeline: ROM model returns `pixel`=1. Required: `color_px`=INK exactly 3 cycles after an inside pixel, and BACKGROUND 3 cycles after an outside pixel.
- Blanking: load 7. Required: digits 0–2 render BACKGROUND even with `pixel`=1, and digit 3 renders INK. Load 0: only digit 3 renders. With BLANK_LEADING=0, all four digits render.
